// File: rtl/ixc_clkgen_pkg.sv
// Shared defaults, config record and helpers for the multi-channel clock generator.
package ixc_clkgen_pkg;

   localparam int DEF_CNT_W   = 10;
   localparam int DEF_DELTA_W = 11;
   localparam int DEF_HALF    = 625;

   // One channel's configuration write at the default counter width.
   typedef struct packed {
      logic [DEF_CNT_W-1:0] half;
      logic [DEF_CNT_W-1:0] phase;
      logic                 en;
      logic                 restart;
   } chan_cfg_t;

   // A zero half-period or start phase would stall the channel, so 0 reads as 1.
   function automatic int unsigned clamp1(input int unsigned v);
      return (v == 0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/ixc_clk_chan.sv
// One generated clock channel: remaining-time down-counter, phase level,
// sticky overshoot flag and its configuration registers.
module ixc_clk_chan
   import ixc_clkgen_pkg::*;
#(
   parameter int   CNT_W        = DEF_CNT_W,
   parameter int   DELTA_W      = DEF_DELTA_W,
   parameter int   DEFAULT_HALF = DEF_HALF,
   parameter logic EN_INIT      = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELTA_W-1:0] delta,
   input  logic               wr,
   input  logic [CNT_W-1:0]   cfg_half,
   input  logic [CNT_W-1:0]   cfg_phase,
   input  logic               cfg_en,
   input  logic               cfg_restart,
   output logic               phi,
   output logic [CNT_W-1:0]   rem,
   output logic               en,
   output logic               ovs
);

   logic [CNT_W-1:0]   half;
   logic [DELTA_W-1:0] rem_ext;
   logic               advance;
   logic [CNT_W-1:0]   half_new;
   logic [CNT_W-1:0]   phase_new;

   assign rem_ext   = DELTA_W'(rem);
   assign advance   = en && (delta != '0);
   assign half_new  = CNT_W'(clamp1(32'(cfg_half)));
   assign phase_new = CNT_W'(clamp1(32'(cfg_phase)));

   // Advance uses the old half; a write in the same cycle is applied after it,
   // so a restart overrides the advance result and a plain write only changes
   // half for the next reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half <= CNT_W'(DEFAULT_HALF);
         rem  <= CNT_W'(DEFAULT_HALF);
         phi  <= 1'b0;
         en   <= EN_INIT;
         ovs  <= 1'b0;
      end else begin
         if (advance) begin
            if (rem_ext > delta) begin
               rem <= CNT_W'(rem_ext - delta);
            end else begin
               phi <= ~phi;
               rem <= half;
               if (rem_ext < delta) ovs <= 1'b1;
            end
         end
         if (wr) begin
            half <= half_new;
            en   <= cfg_en;
            if (cfg_restart) begin
               rem <= phase_new;
               phi <= 1'b0;
               ovs <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/ixc_multi_clock_gen.sv
// Multi-channel DUT clock generator: write decode to the channels and the
// combinational minimum of remaining time across enabled channels.
module ixc_multi_clock_gen
   import ixc_clkgen_pkg::*;
#(
   parameter int                  NUM_CLKS     = 4,
   parameter int                  CNT_W        = DEF_CNT_W,
   parameter int                  DELTA_W      = DEF_DELTA_W,
   parameter int                  DEFAULT_HALF = DEF_HALF,
   parameter logic [NUM_CLKS-1:0] EN_RESET     = 'b1,
   localparam int                 SEL_W        = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DELTA_W-1:0]  delta,
   input  logic                cfg_we,
   input  logic [SEL_W-1:0]    cfg_sel,
   input  logic [CNT_W-1:0]    cfg_half,
   input  logic [CNT_W-1:0]    cfg_phase,
   input  logic                cfg_en,
   input  logic                cfg_restart,
   output logic [NUM_CLKS-1:0] phi,
   output logic [DELTA_W-1:0]  td_min,
   output logic                td_valid,
   output logic [NUM_CLKS-1:0] overshoot
);

   localparam int LVL_N  = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 0;
   localparam int LEAVES = 1 << LVL_N;

   logic [NUM_CLKS-1:0] wr;
   logic [NUM_CLKS-1:0] chan_en;
   logic [CNT_W-1:0]    rem [NUM_CLKS];

   for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
      // cfg_sel codes beyond the last channel match nothing and are dropped.
      assign wr[i] = cfg_we && (32'(cfg_sel) == i);

      ixc_clk_chan #(
         .CNT_W        (CNT_W),
         .DELTA_W      (DELTA_W),
         .DEFAULT_HALF (DEFAULT_HALF),
         .EN_INIT      (EN_RESET[i])
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .delta       (delta),
         .wr          (wr[i]),
         .cfg_half    (cfg_half),
         .cfg_phase   (cfg_phase),
         .cfg_en      (cfg_en),
         .cfg_restart (cfg_restart),
         .phi         (phi[i]),
         .rem         (rem[i]),
         .en          (chan_en[i]),
         .ovs         (overshoot[i])
      );
   end

   // Heap-ordered min tree; unused and disabled leaves are all ones so they never win.
   logic [DELTA_W-1:0] node [1:2*LEAVES-1];

   // Build leaves from registered rem, then reduce pairwise towards node 1.
   always_comb begin
      for (int k = 1; k < 2 * LEAVES; k++) node[k] = '1;
      for (int k = 0; k < NUM_CLKS; k++) begin
         if (chan_en[k]) node[LEAVES + k] = DELTA_W'(rem[k]);
      end
      for (int k = LEAVES - 1; k >= 1; k--) begin
         node[k] = (node[2*k] < node[2*k+1]) ? node[2*k] : node[2*k+1];
      end
   end

   assign td_min   = node[1];
   assign td_valid = |chan_en;

endmodule

// File: tb/tb_ixc_multi_clock_gen.sv
// Bench for ixc_multi_clock_gen: integer-level channel model compared every
// cycle, plus hand-computed checkpoints along the directed sequence.
module tb_ixc_multi_clock_gen;
   import ixc_clkgen_pkg::*;

   // Five channels so cfg_sel (3 bits) has codes that address no channel.
   localparam int NC   = 5;
   localparam int ONES = 2047;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [10:0]   delta = '0;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_sel = '0;
   logic [9:0]    cfg_half = '0;
   logic [9:0]    cfg_phase = '0;
   logic          cfg_en = 1'b0;
   logic          cfg_restart = 1'b0;
   logic [NC-1:0] phi;
   logic [10:0]   td_min;
   logic          td_valid;
   logic [NC-1:0] overshoot;

   int errors = 0;
   int checks = 0;

   ixc_multi_clock_gen #(.NUM_CLKS(NC)) dut (
      .clk         (clk),
      .rst         (rst),
      .delta       (delta),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_half    (cfg_half),
      .cfg_phase   (cfg_phase),
      .cfg_en      (cfg_en),
      .cfg_restart (cfg_restart),
      .phi         (phi),
      .td_min      (td_min),
      .td_valid    (td_valid),
      .overshoot   (overshoot)
   );

   always #5 clk = ~clk;

   // Model state: time left to the next edge, period half, enable, level, overshoot.
   int m_rem  [NC];
   int m_half [NC];
   bit m_en   [NC];
   bit m_phi  [NC];
   bit m_ovs  [NC];

   function automatic int exp_td();
      int t = ONES;
      for (int i = 0; i < NC; i++) if (m_en[i] && m_rem[i] < t) t = m_rem[i];
      return t;
   endfunction

   function automatic int exp_vec(input int which);
      int v = 0;
      for (int i = 0; i < NC; i++) begin
         if (which == 0 && m_phi[i]) v |= (1 << i);
         if (which == 1 && m_ovs[i]) v |= (1 << i);
      end
      return v;
   endfunction

   function automatic int exp_valid();
      int v = 0;
      for (int i = 0; i < NC; i++) if (m_en[i]) v = 1;
      return v;
   endfunction

   // Model update: elapsed time eats into the time left; running out means one edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            m_rem[i]  <= 625;
            m_half[i] <= 625;
            m_en[i]   <= (i == 0);
            m_phi[i]  <= 1'b0;
            m_ovs[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NC; i++) begin
            automatic int r  = m_rem[i];
            automatic int h  = m_half[i];
            automatic bit e  = m_en[i];
            automatic bit p  = m_phi[i];
            automatic bit o  = m_ovs[i];
            automatic int dt = int'(delta);
            if (e && dt != 0) begin
               if (dt >= r) begin
                  p = !p;
                  if (dt > r) o = 1'b1;
                  r = h;
               end else begin
                  r = r - dt;
               end
            end
            if (cfg_we && int'(cfg_sel) == i) begin
               h = (cfg_half == 0) ? 1 : int'(cfg_half);
               e = cfg_en;
               if (cfg_restart) begin
                  r = (cfg_phase == 0) ? 1 : int'(cfg_phase);
                  p = 1'b0;
                  o = 1'b0;
               end
            end
            m_rem[i]  <= r;
            m_half[i] <= h;
            m_en[i]   <= e;
            m_phi[i]  <= p;
            m_ovs[i]  <= o;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every falling edge: outputs against the model.
   always @(negedge clk) begin
      chk("phi", int'(phi), exp_vec(0));
      chk("overshoot", int'(overshoot), exp_vec(1));
      chk("td_min", int'(td_min), exp_td());
      chk("td_valid", int'(td_valid), exp_valid());
   end

   function automatic chan_cfg_t mk(input int h, input int p, input bit e, input bit r);
      chan_cfg_t c;
      c.half    = 10'(h);
      c.phase   = 10'(p);
      c.en      = e;
      c.restart = r;
      return c;
   endfunction

   // One clock: present delta and an optional write, then settle just after the edge.
   task automatic cyc(input int d, input bit we = 1'b0, input int sel = 0,
                      input chan_cfg_t c = '0);
      delta       = 11'(d);
      cfg_we      = we;
      cfg_sel     = 3'(sel);
      cfg_half    = c.half;
      cfg_phase   = c.phase;
      cfg_en      = c.en;
      cfg_restart = c.restart;
      @(posedge clk);
      #1;
      delta  = '0;
      cfg_we = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_td_min", int'(td_min), 625);
      chk("rst_td_valid", int'(td_valid), 1);
      chk("rst_phi", int'(phi), 0);

      // Default half, delta equal to it: ch0 toggles every cycle, others idle.
      cyc(625);
      chk("full_phi_a", int'(phi), 1);
      chk("full_td", int'(td_min), 625);
      cyc(625);
      chk("full_phi_b", int'(phi), 0);
      cyc(625);
      chk("full_phi_c", int'(phi), 1);

      // delta=125: five advances per edge.
      cyc(125); chk("d125_td1", int'(td_min), 500);
      cyc(125); chk("d125_td2", int'(td_min), 375);
      cyc(125); chk("d125_td3", int'(td_min), 250);
      cyc(125); chk("d125_td4", int'(td_min), 125);
      chk("d125_phi_held", int'(phi[0]), 1);
      cyc(125); chk("d125_td5", int'(td_min), 625);
      chk("d125_phi_tog", int'(phi[0]), 0);

      // Channel 1 restart with phase 100 / half 300, then delta = td_min.
      cyc(0, 1'b1, 1, mk(300, 100, 1'b1, 1'b1));
      chk("ch1_td0", int'(td_min), 100);
      cyc(100); chk("ch1_td1", int'(td_min), 300);
      chk("ch1_phi1", int'(phi[1]), 1);
      cyc(300); chk("ch1_td2", int'(td_min), 225);
      chk("ch1_phi2", int'(phi[1]), 0);
      cyc(225); chk("ch1_td3", int'(td_min), 75);
      chk("ch0_phi3", int'(phi[0]), 1);
      cyc(75);  chk("ch1_td4", int'(td_min), 300);
      chk("ch1_phi4", int'(phi[1]), 1);

      // Overshoot on ch0: one toggle only, sticky until a restart.
      cyc(0, 1'b1, 1, mk(300, 0, 1'b0, 1'b0));
      cyc(0, 1'b1, 0, mk(625, 625, 1'b1, 1'b1));
      chk("ovs_pre_td", int'(td_min), 625);
      cyc(700);
      chk("ovs_phi", int'(phi[0]), 1);
      chk("ovs_td", int'(td_min), 625);
      chk("ovs_set", int'(overshoot), 1);
      cyc(0); cyc(0);
      cyc(100);
      chk("ovs_sticky", int'(overshoot), 1);
      chk("ovs_td2", int'(td_min), 525);
      cyc(0, 1'b1, 0, mk(625, 625, 1'b1, 1'b1));
      chk("ovs_clear", int'(overshoot), 0);

      // Zero half and phase clamp to 1.
      cyc(0, 1'b1, 0, mk(0, 0, 1'b1, 1'b1));
      chk("clamp_td", int'(td_min), 1);
      cyc(1);
      chk("clamp_td2", int'(td_min), 1);
      chk("clamp_phi", int'(phi[0]), 1);
      cyc(0, 1'b1, 0, mk(625, 625, 1'b0, 1'b1));

      // Same-cycle write and due advance on ch2.
      cyc(0, 1'b1, 2, mk(625, 50, 1'b1, 1'b1));
      chk("same_td0", int'(td_min), 50);
      cyc(50, 1'b1, 2, mk(625, 50, 1'b1, 1'b1));
      chk("same_rst_phi", int'(phi[2]), 0);
      chk("same_rst_td", int'(td_min), 50);
      cyc(50);
      chk("same_tog_phi", int'(phi[2]), 1);
      chk("same_tog_td", int'(td_min), 625);
      cyc(625, 1'b1, 2, mk(200, 0, 1'b1, 1'b0));
      chk("same_old_half", int'(td_min), 625);
      chk("same_old_phi", int'(phi[2]), 0);
      cyc(625);
      chk("same_new_half", int'(td_min), 200);
      cyc(200);
      chk("same_new_half2", int'(td_min), 200);

      // All channels running, then an asynchronous reset mid-cycle.
      cyc(0, 1'b1, 0, mk(625, 625, 1'b1, 1'b1));
      cyc(0, 1'b1, 1, mk(150, 100, 1'b1, 1'b1));
      cyc(0, 1'b1, 3, mk(350, 300, 1'b1, 1'b1));
      cyc(0, 1'b1, 4, mk(450, 400, 1'b1, 1'b1));
      for (int k = 0; k < 6; k++) cyc(exp_td());
      cyc(700);
      chk("pre_rst_ovs", int'(overshoot), 31);
      #2 rst = 1'b1;
      #1;
      chk("async_phi", int'(phi), 0);
      chk("async_ovs", int'(overshoot), 0);
      chk("async_td", int'(td_min), 625);
      chk("async_valid", int'(td_valid), 1);
      @(posedge clk);
      #1 rst = 1'b0;

      // Writes to unpopulated channel codes are dropped.
      cyc(0, 1'b1, 5, mk(10, 10, 1'b1, 1'b1));
      cyc(0, 1'b1, 7, mk(10, 10, 1'b1, 1'b1));
      chk("sel_oob_td", int'(td_min), 625);
      cyc(625);
      chk("post_rst_phi", int'(phi), 1);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
